// File: rtl/sp_ram_arb_pkg.sv
// -----------------------------------------------------------------------------
// sp_ram_arb_pkg
// Shared constants and types for the two-master single-port RAM arbiter.
//   NUM_MASTERS : number of requesting masters (core data port + debug port)
//   M_CORE      : master index of the core data port
//   M_DBG       : master index of the debug/loader port
//   resp_t      : response pipeline entry captured on the grant cycle
// -----------------------------------------------------------------------------
package sp_ram_arb_pkg;

    localparam int   NUM_MASTERS = 2;
    localparam logic M_CORE      = 1'b0;
    localparam logic M_DBG       = 1'b1;

    // One in-flight response: issued on the grant cycle, presented the next.
    typedef struct packed {
        logic valid;   // a transaction was granted
        logic idx;     // which master owns the response
        logic err;     // address was outside the RAM window
        logic we;      // transaction was a write (no read data returned)
    } resp_t;

endpackage

// File: rtl/sp_ram_arbiter_rr_arb_2.sv
// -----------------------------------------------------------------------------
// rr_arb_2
// Two-input round-robin arbiter. The grant is combinational from the request
// vector and the last-winner register; on contention the master that did not
// win last time is chosen. Grants are suppressed while reset is asserted.
// Ports:
//   clk    : clock, rising edge
//   rst_i  : synchronous active-high reset (last winner resets to master 1)
//   i_req  : per-master request
//   o_gnt  : one-hot or zero grant
//   o_idx  : index of the granted master (meaningful only when o_gnt != 0)
// -----------------------------------------------------------------------------
module rr_arb_2 (
    input  logic       clk,
    input  logic       rst_i,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt,
    output logic       o_idx
);

    logic       r_last;
    logic [1:0] w_gnt;

    always_comb begin
        w_gnt = 2'b00;
        if (!rst_i) begin
            case (i_req)
                2'b01:   w_gnt = 2'b01;
                2'b10:   w_gnt = 2'b10;
                // Contention: favour whichever master lost last time.
                2'b11:   w_gnt = r_last ? 2'b01 : 2'b10;
                default: w_gnt = 2'b00;
            endcase
        end
    end

    assign o_gnt = w_gnt;
    assign o_idx = w_gnt[1];

    // Resetting to master 1 makes master 0 win the first contention.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            r_last <= 1'b1;
        end else if (|w_gnt) begin
            r_last <= w_gnt[1];
        end
    end

endmodule

// File: rtl/sp_ram_arbiter.sv
// -----------------------------------------------------------------------------
// sp_ram_arbiter
// Round-robin arbiter between the core data port (master 0) and the
// debug/loader port (master 1) in front of a single-port RAM wrapper.
// One transaction per cycle; the response (rvalid/rdata/err) appears in the
// cycle after the grant. Addresses outside [RAM_BASE, RAM_BASE+RAM_SIZE) never
// reach the RAM and complete with an error response.
// Ports:
//   clk, rst_i              : clock / synchronous active-high reset
//   m_req_i, m_addr_i,
//   m_we_i, m_be_i,
//   m_wdata_i               : per-master request (held stable until granted)
//   m_gnt_o                 : combinational grant, one-hot or zero
//   m_rvalid_o              : per-master response valid, one cycle after grant
//   m_rdata_o, m_err_o      : shared response data / error, qualified by rvalid
//   ram_en_o, ram_addr_o,
//   ram_we_o, ram_be_o,
//   ram_wdata_o             : RAM wrapper command (address word aligned)
//   ram_rdata_i             : RAM read data, valid the cycle after ram_en_o
// -----------------------------------------------------------------------------
module sp_ram_arbiter
    import sp_ram_arb_pkg::*;
#(
    parameter int          RAM_SIZE   = 32768,
    parameter int          ADDR_WIDTH = $clog2(RAM_SIZE),
    parameter logic [31:0] RAM_BASE   = 32'h0010_0000
) (
    input  logic                        clk,
    input  logic                        rst_i,
    input  logic [NUM_MASTERS-1:0]      m_req_i,
    input  logic [NUM_MASTERS-1:0][31:0] m_addr_i,
    input  logic [NUM_MASTERS-1:0]      m_we_i,
    input  logic [NUM_MASTERS-1:0][3:0] m_be_i,
    input  logic [NUM_MASTERS-1:0][31:0] m_wdata_i,
    output logic [NUM_MASTERS-1:0]      m_gnt_o,
    output logic [NUM_MASTERS-1:0]      m_rvalid_o,
    output logic [31:0]                 m_rdata_o,
    output logic                        m_err_o,
    output logic                        ram_en_o,
    output logic [ADDR_WIDTH-1:0]       ram_addr_o,
    output logic                        ram_we_o,
    output logic [3:0]                  ram_be_o,
    output logic [31:0]                 ram_wdata_o,
    input  logic [31:0]                 ram_rdata_i
);

    // ---------------------------------------------------------------------
    // Arbitration
    // ---------------------------------------------------------------------
    logic [NUM_MASTERS-1:0] w_gnt;
    logic                   w_idx;
    logic                   w_any_gnt;

    rr_arb_2 u_rr_arb (
        .clk   (clk),
        .rst_i (rst_i),
        .i_req (m_req_i),
        .o_gnt (w_gnt),
        .o_idx (w_idx)
    );

    assign m_gnt_o   = w_gnt;
    assign w_any_gnt = |w_gnt;

    // ---------------------------------------------------------------------
    // Per-master range check. The subtraction wraps, so addresses below
    // RAM_BASE become huge offsets and fail the single unsigned compare.
    // ---------------------------------------------------------------------
    logic [31:0]           w_off      [NUM_MASTERS];
    logic                  w_in_range [NUM_MASTERS];
    logic [ADDR_WIDTH-1:0] w_ram_addr [NUM_MASTERS];

    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_range
        assign w_off[gi]      = m_addr_i[gi] - RAM_BASE;
        assign w_in_range[gi] = (w_off[gi] < 32'(RAM_SIZE));
        assign w_ram_addr[gi] = w_off[gi][ADDR_WIDTH-1:0] & ~ADDR_WIDTH'(3);
    end

    // ---------------------------------------------------------------------
    // Request mux towards the RAM wrapper
    // ---------------------------------------------------------------------
    logic                  w_sel_in_range;
    logic                  w_hit;
    logic [ADDR_WIDTH-1:0] r_addr_hold;
    logic [31:0]           r_wdata_hold;

    assign w_sel_in_range = w_in_range[w_idx];
    assign w_hit          = w_any_gnt & w_sel_in_range;

    assign ram_en_o    = w_hit;
    assign ram_we_o    = w_hit & m_we_i[w_idx];
    assign ram_be_o    = w_hit ? m_be_i[w_idx] : 4'b0000;
    // Address/data keep their last driven value when idle so the RAM pins
    // do not toggle needlessly; they read as zero while reset is held.
    assign ram_addr_o  = rst_i ? '0    : (w_hit ? w_ram_addr[w_idx] : r_addr_hold);
    assign ram_wdata_o = rst_i ? 32'h0 : (w_hit ? m_wdata_i[w_idx]  : r_wdata_hold);

    always_ff @(posedge clk) begin
        if (rst_i) begin
            r_addr_hold  <= '0;
            r_wdata_hold <= 32'h0;
        end else if (w_hit) begin
            r_addr_hold  <= w_ram_addr[w_idx];
            r_wdata_hold <= m_wdata_i[w_idx];
        end
    end

    // ---------------------------------------------------------------------
    // Response pipeline (one stage) and read-data hold register
    // ---------------------------------------------------------------------
    resp_t       r_resp;
    logic [31:0] w_resp_data;
    logic [31:0] r_rdata_hold;

    always_ff @(posedge clk) begin
        if (rst_i) begin
            r_resp <= '0;
        end else begin
            r_resp.valid <= w_any_gnt;
            r_resp.idx   <= w_idx;
            r_resp.err   <= ~w_sel_in_range;
            r_resp.we    <= m_we_i[w_idx];
        end
    end

    // Only in-range reads return RAM data; writes and errors return zero.
    assign w_resp_data = (r_resp.valid && !r_resp.err && !r_resp.we) ? ram_rdata_i : 32'h0;

    always_ff @(posedge clk) begin
        if (rst_i) begin
            r_rdata_hold <= 32'h0;
        end else if (r_resp.valid) begin
            r_rdata_hold <= w_resp_data;
        end
    end

    // Reset in the response cycle drops the pending response outright.
    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_rvalid
        assign m_rvalid_o[gi] = ~rst_i & r_resp.valid & (r_resp.idx == 1'(gi));
    end

    assign m_rdata_o = rst_i ? 32'h0 : (r_resp.valid ? w_resp_data : r_rdata_hold);
    assign m_err_o   = ~rst_i & r_resp.valid & r_resp.err;

endmodule
